// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;
    typedef logic [1:0]  state_t;

    localparam state_t ST_BOOT   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_HALTED = 2'd2;

    localparam addr_t RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction FIFO holding {pc, inst} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_wr && !i_flush)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_wr) r_wptr <= r_wptr + 1'b1;
            if (i_rd) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_wr) - (AW+1)'(i_rd);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_cnt;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: PC, ROM read issue, response buffering, redirect/halt handling.
// Optional perf counters (perf_fetch, perf_bubble) are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF,
    parameter int    FQ_DEPTH = 2,
    parameter int    FQ_AW    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;
    addr_t         r_pc;
    addr_t         r_tag_pc;
    logic          r_inflight;
    logic [FQ_AW:0]   w_cnt;
    logic [FQ_AW+1:0] w_occ;
    logic [31:0]   w_head;
    logic          w_redirect;
    logic          w_deq;
    logic          w_issue;
    logic          w_wr;

    // Redirects are ignored in BOOT; elsewhere they pre-empt halt and the response write.
    assign w_redirect = redirect && (r_state != ST_BOOT);
    assign inst_valid = (w_cnt != '0);
    assign w_deq      = inst_valid && inst_ready;

    // Credit counts the slot freed by a same-cycle dequeue so fetch streams at 1/cycle.
    assign w_occ   = {1'b0, w_cnt} + (FQ_AW+2)'(r_inflight) - (FQ_AW+2)'(w_deq);
    assign w_issue = (r_state == ST_RUN) && !w_redirect && (w_occ < (FQ_AW+2)'(FQ_DEPTH));
    // A response arriving during a redirect belongs to the old stream and is dropped.
    assign w_wr    = r_inflight && !w_redirect;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN:    if (!w_redirect && halt_req) w_state_nxt = ST_HALTED;
            ST_HALTED: if (w_redirect || !halt_req) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_tag_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc     <= r_pc + 16'd1;
                r_tag_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .AW    (FQ_AW),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_redirect),
        .i_wr    (w_wr),
        .i_wdata ({r_tag_pc, imem_rdata}),
        .i_rd    (w_deq),
        .o_rdata (w_head),
        .o_count (w_cnt)
    );

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_pc;
    assign inst_pc    = w_head[31:16];
    assign inst       = w_head[15:0];
    assign halted     = (r_state == ST_HALTED) && (w_cnt == '0) && !r_inflight;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_issue && (r_perf_fetch != 32'hFFFF_FFFF))
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (inst_ready && !inst_valid && (r_state == ST_RUN) &&
                (r_perf_bubble != 32'hFFFF_FFFF))
                r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: per-cycle vector table plus wrap and async-reset sequences.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    int n_chk;
    int n_err;

    fetch_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: ROM[i] = i + 0x100, data one cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= imem_addr + 16'h0100;
    end

    typedef struct {
        logic        rdy;
        logic        hlt_req;
        logic        redir;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_pc;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, input logic h, input logic r, input logic [15:0] rpc,
                       input logic erd, input logic [15:0] ea, input logic ev,
                       input logic [15:0] ep, input logic eh);
        vec_t v;
        v.rdy = rdy; v.hlt_req = h; v.redir = r; v.rpc = rpc;
        v.e_rd = erd; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep; v.e_halted = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Check the outputs visible in the current cycle against one expectation record.
    task automatic chk_cycle(input string tag, input vec_t v);
        chk({tag, " rd_en"}, 32'(imem_rd_en), 32'(v.e_rd));
        if (v.e_rd) chk({tag, " addr"}, 32'(imem_addr), 32'(v.e_addr));
        chk({tag, " valid"}, 32'(inst_valid), 32'(v.e_vld));
        if (v.e_vld) begin
            chk({tag, " inst_pc"}, 32'(inst_pc), 32'(v.e_pc));
            chk({tag, " inst"}, 32'(inst), 32'(16'(v.e_pc + 16'h0100)));
        end
        chk({tag, " halted"}, 32'(halted), 32'(v.e_halted));
    endtask

    task automatic drive(input logic rdy, input logic h, input logic r, input logic [15:0] rpc);
        inst_ready  = rdy;
        halt_req    = h;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    initial begin
        vec_t v;
        logic [15:0] got_pc[$];
        logic [15:0] got_inst[$];
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);

        // rdy hlt rdr rpc    rd  addr     vld pc       halted
        add(1, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0);   // BOOT
        add(1, 0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0002, 1, 16'h0000, 0);   // first valid, 3 cycles in
        add(1, 0, 0, 16'h0, 1, 16'h0003, 1, 16'h0001, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0004, 1, 16'h0002, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 16'h0, 0, 16'h0000, 1, 16'h0003, 0);   // stall: FIFO fills, no issue
        add(1, 0, 0, 16'h0, 1, 16'h0005, 1, 16'h0003, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0006, 1, 16'h0004, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0007, 1, 16'h0005, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0008, 1, 16'h0006, 0);
        add(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0007, 0); // redirect, read 8 in flight
        add(1, 0, 0, 16'h0, 1, 16'h0040, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0041, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0042, 1, 16'h0040, 0);
        add(1, 1, 0, 16'h0, 1, 16'h0043, 1, 16'h0041, 0);   // halt seen in RUN
        add(1, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0042, 0);
        add(1, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0043, 0);
        add(1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);   // drained
        add(1, 1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 1);
        add(1, 0, 0, 16'h0, 1, 16'h0010, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0011, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0012, 1, 16'h0010, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset rd_en", 32'(imem_rd_en), 32'd0);
        chk("reset valid", 32'(inst_valid), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset perf_fetch", perf_fetch, 32'd0);
        chk("reset perf_bubble", perf_bubble, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.rdy, v.hlt_req, v.redir, v.rpc);
            #1;
            chk_cycle($sformatf("vec%0d", i), v);
            @(negedge clk);
        end

        // Wrap: redirect to FFFE and collect the first three delivered instructions.
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (inst_valid) begin
                got_pc.push_back(inst_pc);
                got_inst.push_back(inst);
            end
            @(negedge clk);
        end
        chk("wrap count>=3", 32'(got_pc.size() >= 3), 32'd1);
        if (got_pc.size() >= 3) begin
            chk("wrap pc0", 32'(got_pc[0]), 32'h0000_FFFE);
            chk("wrap pc1", 32'(got_pc[1]), 32'h0000_FFFF);
            chk("wrap pc2", 32'(got_pc[2]), 32'h0000_0000);
            chk("wrap inst0", 32'(got_inst[0]), 32'h0000_00FE);
            chk("wrap inst2", 32'(got_inst[2]), 32'h0000_0100);
        end

        // Async reset mid-stream, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(inst_valid), 32'd0);
        chk("midrst rd_en", 32'(imem_rd_en), 32'd0);
        chk("midrst halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst perf_fetch", perf_fetch, 32'd0);
        chk("midrst perf_bubble", perf_bubble, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add(1, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0, 1, 16'h0002, 1, 16'h0000, 0);
        for (int i = vecs.size() - 4; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rdy, v.hlt_req, v.redir, v.rpc);
            #1;
            chk_cycle($sformatf("restart%0d", i), v);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
